ram_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of the 128 x 32 register-file RAM.
- Port A is typically instruction fetch and port B load/store, but the two ports are symmetric.
- It latches the winning command, drives the RAM's rd_en, wr_en, addr and data_in for exactly one cycle, and registers read data back to the winner with a one-cycle valid pulse.

---
 rtl/ram_arbiter.sv | 139 +++++++++++++
 tb/tb_ram_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter that sequences two symmetric requesters onto one single-port RAM.
// Latency: gnt the cycle after req is sampled, read data and rvalid one cycle later; requesters hold req until gnt.
module ram_arbiter #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [WORD_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [WORD_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [WORD_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [WORD_WIDTH-1:0] b_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WORD_WIDTH-1:0] ram_data_in,
    output logic                  ram_rd_en,
    output logic                  ram_wr_en,
    input  logic [WORD_WIDTH-1:0] ram_data_out,
    output logic                  busy
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   ptr;        // tie-break owner: 0 = A, 1 = B
    logic   win;        // port of the latched command: 0 = A, 1 = B
    logic   lat_we;
    logic   take;
    logic   pick_b;
    logic   win_d;
    logic   we_d;
    logic   a_gnt_d;
    logic   b_gnt_d;
    logic   a_rvalid_d;
    logic   b_rvalid_d;
    logic   rd_en_d;
    logic   wr_en_d;
    logic   busy_d;

    assign take   = (state == IDLE) && (a_req || b_req);
    assign pick_b = b_req && (!a_req || ptr);
    assign win_d  = take ? pick_b : win;
    assign we_d   = take ? (pick_b ? b_we : a_we) : lat_we;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take) state_next = ACCESS;
            ACCESS:  state_next = lat_we ? IDLE : RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed for the state being entered so every port leaves a flop.
    always_comb begin
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        rd_en_d    = 1'b0;
        wr_en_d    = 1'b0;
        busy_d     = (state_next != IDLE);
        if (state_next == ACCESS) begin
            a_gnt_d = !win_d;
            b_gnt_d = win_d;
            rd_en_d = !we_d;
            wr_en_d = we_d;
        end
        if (state_next == RESP) begin
            a_rvalid_d = !win_d;
            b_rvalid_d = win_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_gnt       <= 1'b0;
            b_gnt       <= 1'b0;
            a_rvalid    <= 1'b0;
            b_rvalid    <= 1'b0;
            ram_rd_en   <= 1'b0;
            ram_wr_en   <= 1'b0;
            busy        <= 1'b0;
            ptr         <= 1'b0;
            win         <= 1'b0;
            lat_we      <= 1'b0;
            ram_addr    <= '0;
            ram_data_in <= '0;
            a_rdata     <= '0;
            b_rdata     <= '0;
        end else begin
            a_gnt     <= a_gnt_d;
            b_gnt     <= b_gnt_d;
            a_rvalid  <= a_rvalid_d;
            b_rvalid  <= b_rvalid_d;
            ram_rd_en <= rd_en_d;
            ram_wr_en <= wr_en_d;
            busy      <= busy_d;
            if (take) begin
                win         <= pick_b;
                lat_we      <= we_d;
                ram_addr    <= pick_b ? b_addr : a_addr;
                ram_data_in <= pick_b ? b_wdata : a_wdata;
            end
            if (state == ACCESS) begin
                ptr <= !win;
                if (!lat_we) begin
                    if (win) begin
                        b_rdata <= ram_data_out;
                    end else begin
                        a_rdata <= ram_data_out;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: cycle table for directed corners, then a transaction-timeline model
// checking every cycle under fixed contention and randomized traffic against a behavioural RAM.
module tb_ram_arbiter;
    localparam int AW = 7;
    localparam int WW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr, ram_addr;
    logic [WW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_data_in, ram_data_out;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid, ram_rd_en, ram_wr_en, busy;
    logic          ram_init;

    always #5 clk = ~clk;

    ram_arbiter #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_rd_en(ram_rd_en),
        .ram_wr_en(ram_wr_en), .ram_data_out(ram_data_out), .busy(busy)
    );

    function automatic logic [WW-1:0] init_word(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    logic [WW-1:0] ram_mem [2**AW];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 2**AW; i++) ram_mem[i] <= init_word(i);
        end else if (ram_wr_en) begin
            ram_mem[ram_addr] <= ram_data_in;
        end
    end
    always_comb ram_data_out = ram_rd_en ? ram_mem[ram_addr] : (32'hBAD0_0000 | 32'(ram_addr));

    typedef struct packed {
        logic a_gnt, a_rvalid, b_gnt, b_rvalid, rd_en, wr_en, busy;
        logic [AW-1:0] addr;
        logic [WW-1:0] din, a_rdata, b_rdata;
    } outs_t;

    typedef struct {
        logic          rst;
        logic          a_req, a_we;
        logic [AW-1:0] a_addr;
        logic [WW-1:0] a_wdata;
        logic          b_req, b_we;
        logic [AW-1:0] b_addr;
        logic [WW-1:0] b_wdata;
        outs_t         exp;
    } vec_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [WW-1:0] wdata;
        int            gap;
    } cmd_t;

    int n_vec = 0;
    int n_bad = 0;

    function automatic outs_t mk_o(input logic ag, av, bg, bv, rd, wr, bsy, input int addr,
                                   input logic [WW-1:0] din, ard, brd);
        outs_t o;
        o.a_gnt = ag; o.a_rvalid = av; o.b_gnt = bg; o.b_rvalid = bv;
        o.rd_en = rd; o.wr_en = wr; o.busy = bsy; o.addr = AW'(addr);
        o.din = din; o.a_rdata = ard; o.b_rdata = brd;
        return o;
    endfunction

    function automatic vec_t mk_v(input logic r, ar, aw, input int aa, input logic [WW-1:0] ad,
                                  input logic br, bw, input int ba, input logic [WW-1:0] bd, input outs_t e);
        vec_t v;
        v.rst = r; v.a_req = ar; v.a_we = aw; v.a_addr = AW'(aa); v.a_wdata = ad;
        v.b_req = br; v.b_we = bw; v.b_addr = AW'(ba); v.b_wdata = bd; v.exp = e;
        return v;
    endfunction

    function automatic outs_t sample_outs();
        outs_t s;
        s.a_gnt = a_gnt; s.a_rvalid = a_rvalid; s.b_gnt = b_gnt; s.b_rvalid = b_rvalid;
        s.rd_en = ram_rd_en; s.wr_en = ram_wr_en; s.busy = busy; s.addr = ram_addr;
        s.din = ram_data_in; s.a_rdata = a_rdata; s.b_rdata = b_rdata;
        return s;
    endfunction

    function automatic string fmt(input outs_t o);
        return $sformatf("ag=%b av=%b bg=%b bv=%b rd=%b wr=%b busy=%b addr=%0d din=%h ard=%h brd=%h",
                         o.a_gnt, o.a_rvalid, o.b_gnt, o.b_rvalid, o.rd_en, o.wr_en, o.busy,
                         o.addr, o.din, o.a_rdata, o.b_rdata);
    endfunction

    task automatic check(input string name, input outs_t exp);
        outs_t act;
        act = sample_outs();
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got [%s] want [%s]", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_val(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: a timeline of when each granted transaction shows up on the outputs.
    int            cyc, g_cyc, rv_cyc, free_cyc, g_port, rv_port;
    logic          ptr_m;
    logic [AW-1:0] m_addr, p_addr;
    logic [WW-1:0] m_din, p_din, p_rd;
    logic [WW-1:0] m_rd [2];
    logic [WW-1:0] model_mem [2**AW];
    cmd_t          cq [2][$];
    cmd_t          cur [2];
    logic          act [2];
    logic          have [2];
    int            gap_cnt [2];
    int            dut_order [$];

    task automatic model_reset();
        cyc = 0; g_cyc = -1; rv_cyc = -1; free_cyc = 0; g_port = 0; rv_port = 0;
        ptr_m = 1'b0; m_addr = '0; p_addr = '0; m_din = '0; p_din = '0; p_rd = '0;
        m_rd[0] = '0; m_rd[1] = '0;
        for (int i = 0; i < 2**AW; i++) model_mem[i] = init_word(i);
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0; have[p] = 1'b0; gap_cnt[p] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; a_req = 1'b0; b_req = 1'b0; ram_init = 1'b1;
        @(posedge clk); #1;
        ram_init = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic run_engine(input int budget, input bit rnd);
        int   start;
        bit   done;
        logic w, gw;
        outs_t e;
        start = cyc;
        dut_order.delete();
        forever begin
            for (int p = 0; p < 2; p++) begin
                gw = (p == 0) ? a_gnt : b_gnt;
                if (act[p] && gw) begin
                    act[p] = 1'b0; have[p] = 1'b0;
                end else if (act[p] && rnd && $urandom_range(15) == 0) begin
                    act[p] = 1'b0; gap_cnt[p] = 1 + $urandom_range(1);
                end
                if (!act[p]) begin
                    if (!have[p] && cq[p].size() > 0) begin
                        cur[p] = cq[p].pop_front(); have[p] = 1'b1; gap_cnt[p] = cur[p].gap;
                    end
                    if (have[p]) begin
                        if (gap_cnt[p] == 0) act[p] = 1'b1;
                        else gap_cnt[p]--;
                    end
                end
            end
            a_req = act[0];
            a_we = have[0] ? cur[0].we : 1'($urandom);
            a_addr = have[0] ? cur[0].addr : AW'($urandom);
            a_wdata = have[0] ? cur[0].wdata : $urandom;
            b_req = act[1];
            b_we = have[1] ? cur[1].we : 1'($urandom);
            b_addr = have[1] ? cur[1].addr : AW'($urandom);
            b_wdata = have[1] ? cur[1].wdata : $urandom;

            @(negedge clk);
            if (a_gnt === 1'b1) dut_order.push_back(0);
            if (b_gnt === 1'b1) dut_order.push_back(1);
            if (cyc == g_cyc) begin
                m_addr = p_addr; m_din = p_din;
            end
            if (cyc == rv_cyc) m_rd[rv_port] = p_rd;
            e.a_gnt = (cyc == g_cyc) && (g_port == 0);
            e.b_gnt = (cyc == g_cyc) && (g_port == 1);
            e.a_rvalid = (cyc == rv_cyc) && (rv_port == 0);
            e.b_rvalid = (cyc == rv_cyc) && (rv_port == 1);
            e.rd_en = (cyc == g_cyc) && (rv_cyc == cyc + 1);
            e.wr_en = (cyc == g_cyc) && (rv_cyc != cyc + 1);
            e.busy = (cyc == g_cyc) || (cyc == rv_cyc);
            e.addr = m_addr; e.din = m_din; e.a_rdata = m_rd[0]; e.b_rdata = m_rd[1];
            check($sformatf("cycle%0d", cyc), e);

            if (cyc >= free_cyc && (a_req || b_req)) begin
                w = (a_req && b_req) ? ptr_m : b_req;
                g_cyc = cyc + 1; g_port = int'(w);
                p_addr = w ? b_addr : a_addr;
                p_din = w ? b_wdata : a_wdata;
                if (w ? b_we : a_we) begin
                    model_mem[p_addr] = p_din;
                    rv_cyc = -1;
                    free_cyc = cyc + 2;
                end else begin
                    p_rd = model_mem[p_addr];
                    rv_cyc = cyc + 2; rv_port = int'(w);
                    free_cyc = cyc + 3;
                end
                ptr_m = !w;
            end
            done = (cq[0].size() == 0) && (cq[1].size() == 0) && !have[0] && !have[1] && (cyc >= free_cyc - 1);
            @(posedge clk); #1;
            cyc++;
            if (done) break;
            if (cyc - start > budget) begin
                n_vec++; n_bad++;
                $display("FAIL engine_timeout: pending commands still queued after %0d cycles, want 0", budget);
                break;
            end
        end
        a_req = 1'b0; b_req = 1'b0;
    endtask

    localparam logic [WW-1:0] K = 32'hC0DE_000A;
    localparam logic [WW-1:0] L = 32'hC0DE_0014;
    localparam logic [WW-1:0] D = 32'hDEAD_BEEF;
    localparam logic [WW-1:0] O = 32'h1111_1111;
    localparam logic [WW-1:0] P = 32'hAAAA_0001;
    localparam logic [WW-1:0] Q = 32'hAAAA_0002;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs [$];
        outs_t z;
        cmd_t  c;
        z = mk_o(0,0,0,0,0,0,0, 0, 0, 0, 0);
        // reset with both requesting, then A wins by the reset pointer
        vecs.push_back(mk_v(0, 1,0,10,0, 1,0,20,0, z));
        vecs.push_back(mk_v(0, 1,0,10,0, 1,0,20,0, z));
        vecs.push_back(mk_v(1, 1,0,10,0, 1,0,20,0, z));
        vecs.push_back(mk_v(1, 0,0,10,0, 1,0,20,0, mk_o(1,0,0,0,1,0,1, 10, 0, 0, 0)));
        vecs.push_back(mk_v(1, 0,0,10,0, 1,0,20,0, mk_o(0,1,0,0,0,0,1, 10, 0, K, 0)));
        vecs.push_back(mk_v(1, 0,0,10,0, 1,0,20,0, mk_o(0,0,0,0,0,0,0, 10, 0, K, 0)));
        vecs.push_back(mk_v(1, 0,0,0,0,  0,0,20,0, mk_o(0,0,1,0,1,0,1, 20, 0, K, 0)));
        vecs.push_back(mk_v(1, 0,0,0,0,  0,0,20,0, mk_o(0,0,0,1,0,0,1, 20, 0, K, L)));
        // write DEADBEEF to 5, read it back
        vecs.push_back(mk_v(1, 1,1,5,D,  0,0,0,0,  mk_o(0,0,0,0,0,0,0, 20, 0, K, L)));
        vecs.push_back(mk_v(1, 0,0,5,D,  0,0,0,0,  mk_o(1,0,0,0,0,1,1, 5, D, K, L)));
        vecs.push_back(mk_v(1, 1,0,5,0,  0,0,0,0,  mk_o(0,0,0,0,0,0,0, 5, D, K, L)));
        vecs.push_back(mk_v(1, 0,0,5,0,  0,0,0,0,  mk_o(1,0,0,0,1,0,1, 5, 0, K, L)));
        vecs.push_back(mk_v(1, 0,0,5,0,  0,0,0,0,  mk_o(0,1,0,0,0,0,1, 5, 0, D, L)));
        // reset during B's read access
        vecs.push_back(mk_v(1, 0,0,0,0,  1,0,64,0, mk_o(0,0,0,0,0,0,0, 5, 0, D, L)));
        vecs.push_back(mk_v(0, 0,0,0,0,  1,0,64,0, mk_o(0,0,1,0,1,0,1, 64, 0, D, L)));
        vecs.push_back(mk_v(1, 0,0,0,0,  0,0,0,0,  z));
        // B pulses req only while A is in its access: never granted
        vecs.push_back(mk_v(1, 1,1,7,O,  0,0,0,0,  z));
        vecs.push_back(mk_v(1, 0,1,7,O,  1,0,30,0, mk_o(1,0,0,0,0,1,1, 7, O, 0, 0)));
        vecs.push_back(mk_v(1, 0,0,0,0,  0,0,0,0,  mk_o(0,0,0,0,0,0,0, 7, O, 0, 0)));
        // back-to-back writes to 127 then 0, then read both back
        vecs.push_back(mk_v(1, 1,1,127,P, 0,0,0,0, mk_o(0,0,0,0,0,0,0, 7, O, 0, 0)));
        vecs.push_back(mk_v(1, 1,1,0,Q,  0,0,0,0,  mk_o(1,0,0,0,0,1,1, 127, P, 0, 0)));
        vecs.push_back(mk_v(1, 1,1,0,Q,  0,0,0,0,  mk_o(0,0,0,0,0,0,0, 127, P, 0, 0)));
        vecs.push_back(mk_v(1, 0,1,0,Q,  0,0,0,0,  mk_o(1,0,0,0,0,1,1, 0, Q, 0, 0)));
        vecs.push_back(mk_v(1, 1,0,127,0, 0,0,0,0, mk_o(0,0,0,0,0,0,0, 0, Q, 0, 0)));
        vecs.push_back(mk_v(1, 1,0,0,0,  0,0,0,0,  mk_o(1,0,0,0,1,0,1, 127, 0, 0, 0)));
        vecs.push_back(mk_v(1, 1,0,0,0,  0,0,0,0,  mk_o(0,1,0,0,0,0,1, 127, 0, P, 0)));
        vecs.push_back(mk_v(1, 1,0,0,0,  0,0,0,0,  mk_o(0,0,0,0,0,0,0, 127, 0, P, 0)));
        vecs.push_back(mk_v(1, 0,0,0,0,  0,0,0,0,  mk_o(1,0,0,0,1,0,1, 0, 0, P, 0)));
        vecs.push_back(mk_v(1, 0,0,0,0,  0,0,0,0,  mk_o(0,1,0,0,0,0,1, 0, 0, Q, 0)));
        vecs.push_back(mk_v(1, 0,0,0,0,  0,0,0,0,  mk_o(0,0,0,0,0,0,0, 0, 0, Q, 0)));

        rst = 1'b0; ram_init = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        @(posedge clk); #1;
        ram_init = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            a_req = vecs[i].a_req; a_we = vecs[i].a_we; a_addr = vecs[i].a_addr; a_wdata = vecs[i].a_wdata;
            b_req = vecs[i].b_req; b_we = vecs[i].b_we; b_addr = vecs[i].b_addr; b_wdata = vecs[i].b_wdata;
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].exp);
            @(posedge clk); #1;
        end

        // continuous contention: four writes per port, then read them all back
        do_reset();
        for (int i = 0; i < 4; i++) begin
            c.we = 1'b1; c.gap = 0;
            c.addr = AW'(i);      c.wdata = 32'hA000_0000 + 32'(i); cq[0].push_back(c);
            c.addr = AW'(64 + i); c.wdata = 32'hB000_0000 + 32'(i); cq[1].push_back(c);
        end
        run_engine(200, 1'b0);
        check_val("wr_order_len", 32'(dut_order.size()), 32'd8);
        for (int i = 0; i < dut_order.size() && i < 8; i++)
            check_val($sformatf("wr_order%0d", i), 32'(dut_order[i]), 32'(i % 2));
        for (int i = 0; i < 4; i++) begin
            c.we = 1'b0; c.gap = 0; c.wdata = '0;
            c.addr = AW'(i);      cq[0].push_back(c);
            c.addr = AW'(64 + i); cq[1].push_back(c);
        end
        run_engine(200, 1'b0);
        check_val("rd_order_len", 32'(dut_order.size()), 32'd8);
        for (int i = 0; i < dut_order.size() && i < 8; i++)
            check_val($sformatf("rd_order%0d", i), 32'(dut_order[i]), 32'(i % 2));
        check_val("a_rdata_last", a_rdata, 32'hA000_0003);
        check_val("b_rdata_last", b_rdata, 32'hB000_0003);

        // randomized traffic with gaps, withdrawals and edge addresses
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 150; i++) begin
                c.we = 1'($urandom);
                case ($urandom_range(7))
                    0:       c.addr = '0;
                    1:       c.addr = '1;
                    default: c.addr = AW'($urandom);
                endcase
                c.wdata = $urandom;
                c.gap = ($urandom_range(3) == 0) ? int'($urandom_range(4)) : 0;
                cq[p].push_back(c);
            end
        end
        run_engine(4000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
